sd_cmd_framer: RTL and testbench

- Builds the 48-bit SD SPI-mode command frame, sends it byte by byte to the SPI byte shifter, then polls for the R1 response.
- Sits between the SD controller sequencer (upstream) and the SPI byte engine (downstream).
- Gets CRC7 from the team's CRC unit through a start/done handshake and consumes its result.

---
 rtl/sd_cmd_framer.sv | 180 ++++++++++++++++++
 tb/tb_sd_cmd_framer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: builds the 48-bit SD SPI-mode command frame, streams it to the
// SPI byte engine, then polls with 0xFF bytes until an R1 response arrives.
// CRC7 comes from an external CRC unit via a crc_init/crc_done handshake.
// Optional build macro SD_CRC_BYPASS_EN: skip the CRC unit and use fixed tails
// (0x95 for CMD0, 0x87 for CMD8, 0x01 otherwise).
module sd_cmd_framer #(
    parameter int NCR_MAX     = 8,
    parameter int CRC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_start,
    input  logic [5:0]  i_cmd_index,
    input  logic [31:0] i_cmd_arg,
    output logic        o_crc_init,
    output logic [39:0] o_crc_din,
    input  logic        i_crc_done,
    input  logic [6:0]  i_crc_result,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_valid,
    output logic        o_busy,
    output logic [7:0]  o_resp,
    output logic        o_resp_valid,
    output logic        o_err_timeout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CRC_REQ  = 3'd1;
    localparam logic [2:0] S_CRC_WAIT = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_POLL     = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam int CW = $clog2(CRC_TIMEOUT + 1);
    localparam int NW = $clog2(NCR_MAX + 1);

    logic [2:0]    r_state;
    logic [5:0]    r_index;
    logic [31:0]   r_arg;
    logic [7:0]    r_tail;
    logic [2:0]    r_byte_idx;
    logic [NW-1:0] r_poll_cnt;
    logic          r_poll_pend;
    logic [7:0]    r_resp;
    logic          r_err;
`ifndef SD_CRC_BYPASS_EN
    logic [CW-1:0] r_crc_cnt;
`endif

    logic       w_hs;
    logic [7:0] w_tx_byte;

    assign w_hs          = o_tx_valid && i_tx_ready;
    assign o_busy        = (r_state != S_IDLE);
    assign o_tx_valid    = (r_state == S_SEND) || ((r_state == S_POLL) && !r_poll_pend);
    assign o_tx_byte     = w_tx_byte;
    assign o_resp        = r_resp;
    assign o_resp_valid  = (r_state == S_DONE);
    assign o_err_timeout = r_err;
    // Header is only driven while a command is in flight so idle outputs read 0.
    assign o_crc_din     = o_busy ? {2'b01, r_index, r_arg} : 40'd0;
`ifdef SD_CRC_BYPASS_EN
    assign o_crc_init    = 1'b0;
`else
    assign o_crc_init    = (r_state == S_CRC_REQ);
`endif

    // Byte mux: frame bytes in SEND, 0xFF fill in POLL, 0 elsewhere.
    always_comb begin
        w_tx_byte = 8'h00;
        if (r_state == S_SEND) begin
            case (r_byte_idx)
                3'd0:    w_tx_byte = {2'b01, r_index};
                3'd1:    w_tx_byte = r_arg[31:24];
                3'd2:    w_tx_byte = r_arg[23:16];
                3'd3:    w_tx_byte = r_arg[15:8];
                3'd4:    w_tx_byte = r_arg[7:0];
                default: w_tx_byte = r_tail;
            endcase
        end else if (r_state == S_POLL) begin
            w_tx_byte = 8'hFF;
        end
    end

    // Command sequencer: latch, CRC handshake, frame send, R1 polling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_arg       <= '0;
            r_tail      <= '0;
            r_byte_idx  <= '0;
            r_poll_cnt  <= '0;
            r_poll_pend <= 1'b0;
            r_resp      <= '0;
            r_err       <= 1'b0;
`ifndef SD_CRC_BYPASS_EN
            r_crc_cnt   <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_start) begin
                        r_index <= i_cmd_index;
                        r_arg   <= i_cmd_arg;
                        r_state <= S_CRC_REQ;
                    end
                end
`ifdef SD_CRC_BYPASS_EN
                S_CRC_REQ: begin
                    // SPI mode ignores CRC except on CMD0/CMD8 before it is disabled.
                    case (r_index)
                        6'd0:    r_tail <= 8'h95;
                        6'd8:    r_tail <= 8'h87;
                        default: r_tail <= 8'h01;
                    endcase
                    r_byte_idx <= '0;
                    r_state    <= S_SEND;
                end
`else
                S_CRC_REQ: begin
                    r_crc_cnt <= '0;
                    r_state   <= S_CRC_WAIT;
                end
                S_CRC_WAIT: begin
                    // crc_done takes priority over a coincident timeout.
                    if (i_crc_done) begin
                        r_tail     <= {i_crc_result, 1'b1};
                        r_byte_idx <= '0;
                        r_state    <= S_SEND;
                    end else if (r_crc_cnt == CW'(CRC_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_crc_cnt <= r_crc_cnt + 1'b1;
                    end
                end
`endif
                S_SEND: begin
                    if (w_hs) begin
                        if (r_byte_idx == 3'd5) begin
                            r_poll_cnt  <= '0;
                            r_poll_pend <= 1'b0;
                            r_state     <= S_POLL;
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                S_POLL: begin
                    // Only rx bytes answering an outstanding poll byte count; the
                    // trailing echo of the frame's last byte is dropped here.
                    if (w_hs) begin
                        r_poll_pend <= 1'b1;
                    end else if (i_rx_valid && r_poll_pend) begin
                        r_poll_pend <= 1'b0;
                        if (!i_rx_byte[7]) begin
                            r_resp  <= i_rx_byte;
                            r_state <= S_DONE;
                        end else if (r_poll_cnt == NW'(NCR_MAX - 1)) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_framer.sv
// Directed bench for sd_cmd_framer: CRC unit and SPI byte engine are modelled
// inside the per-cycle tick task; each step checks hand-computed values.
module tb_sd_cmd_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_cmd_start = 1'b0;
    logic [5:0]  i_cmd_index = '0;
    logic [31:0] i_cmd_arg = '0;
    logic        o_crc_init;
    logic [39:0] o_crc_din;
    logic        i_crc_done = 1'b0;
    logic [6:0]  i_crc_result = '0;
    logic [7:0]  o_tx_byte;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic [7:0]  i_rx_byte = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_busy;
    logic [7:0]  o_resp;
    logic        o_resp_valid;
    logic        o_err_timeout;

    sd_cmd_framer dut (
        .clk(clk), .reset(reset),
        .i_cmd_start(i_cmd_start), .i_cmd_index(i_cmd_index), .i_cmd_arg(i_cmd_arg),
        .o_crc_init(o_crc_init), .o_crc_din(o_crc_din),
        .i_crc_done(i_crc_done), .i_crc_result(i_crc_result),
        .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid),
        .o_busy(o_busy), .o_resp(o_resp), .o_resp_valid(o_resp_valid),
        .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    logic [7:0] sent_q[$];
    logic [7:0] rx_script[$];
    int crc_en, crc_lat, crc_wait, rdy_toggle;
    logic [6:0] crc_val;
    logic hold_pend;
    logic [7:0] hold_byte;
    int n_resp, n_err, n_crc_init, n_stab;
    int t_start, t_crc_init, t_crc_done, t_first_txv, t_r1, t_resp, t_err;
    logic [39:0] din_at_init;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        sent_q.delete(); rx_script.delete();
        n_resp = 0; n_err = 0; n_crc_init = 0; n_stab = 0; crc_wait = 0;
        t_start = -1; t_crc_init = -1; t_crc_done = -1; t_first_txv = -1;
        t_r1 = -1; t_resp = -1; t_err = -1; hold_pend = 1'b0;
    endtask

    // One clock: model SPI engine echo/response and CRC unit, record events.
    task automatic tick();
        logic hs, is_poll;
        logic [7:0] b;
        hs = o_tx_valid && i_tx_ready;
        b  = o_tx_byte;
        if (o_tx_valid && !i_tx_ready) begin hold_pend = 1'b1; hold_byte = o_tx_byte; end
        @(posedge clk); #1; cyc++;
        if (hs) sent_q.push_back(b);
        is_poll = hs && (sent_q.size() > 6);
        i_rx_valid = hs;
        i_rx_byte  = 8'hFF;
        if (is_poll && rx_script.size() > 0) i_rx_byte = rx_script.pop_front();
        if (is_poll && !i_rx_byte[7]) t_r1 = cyc;
        if (hold_pend) begin
            if (o_tx_valid) begin chk("tx_byte_stable", o_tx_byte, hold_byte); n_stab++; end
            hold_pend = 1'b0;
        end
        i_crc_done = 1'b0;
        if (crc_wait > 0) begin
            crc_wait--;
            if (crc_wait == 0 && crc_en != 0) begin
                i_crc_done = 1'b1; i_crc_result = crc_val; t_crc_done = cyc;
            end
        end
        if (o_crc_init) begin
            n_crc_init++; t_crc_init = cyc; din_at_init = o_crc_din; crc_wait = crc_lat;
        end
        if (o_tx_valid && t_first_txv < 0) t_first_txv = cyc;
        if (o_resp_valid) begin n_resp++; t_resp = cyc; end
        if (o_err_timeout) begin n_err++; t_err = cyc; end
        i_tx_ready = (rdy_toggle != 0) ? ~i_tx_ready : 1'b1;
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg);
        i_cmd_start = 1'b1; i_cmd_index = idx; i_cmd_arg = arg; t_start = cyc;
        tick();
        i_cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (!((n_resp + n_err) > 0 && !o_busy) && k < limit) begin tick(); k++; end
        chk({tag, "_bound"}, 64'(k < limit), 64'd1);
    endtask

    task automatic wait_sent(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (sent_q.size() < n && k < limit) begin tick(); k++; end
        chk({tag, "_bound"}, 64'(k < limit), 64'd1);
    endtask

    task automatic chk_frame(input string tag, input logic [47:0] exp);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_byte%0d", tag, i),
                (sent_q.size() > i) ? 64'(sent_q[i]) : 64'hDEAD, 64'(exp[47 - 8*i -: 8]));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk(tag, {o_busy, o_tx_valid, o_crc_init, o_resp_valid, o_err_timeout,
                  o_tx_byte, o_resp, o_crc_din[31:0]}, 64'd0);
        chk({tag, "_din_hi"}, 64'(o_crc_din[39:32]), 64'd0);
    endtask

    initial begin
        crc_en = 1; crc_lat = 2; crc_val = '0; rdy_toggle = 0;
        clr();
        // Reset state
        tick(); tick();
        chk_idle_zero("reset");
        reset = 1'b0;
        tick();

        // CMD0: CRC 0x4A -> tail 0x95; two 0xFF polls then R1=0x01
        clr(); crc_val = 7'h4A;
        rx_script.push_back(8'hFF); rx_script.push_back(8'hFF); rx_script.push_back(8'h01);
        start_cmd(6'd0, 32'h0);
        wait_done("cmd0", 200);
        chk("cmd0_init_lat", 64'(t_crc_init - t_start), 64'd1);
        chk("cmd0_din", 64'(din_at_init), 64'h40_0000_0000);
        chk("cmd0_txv_lat", 64'(t_first_txv - t_crc_done), 64'd1);
        chk_frame("cmd0", 48'h40_00_00_00_00_95);
        chk("cmd0_nbytes", 64'(sent_q.size()), 64'd9);
        chk("cmd0_resp", 64'(o_resp), 64'h01);
        chk("cmd0_nresp", 64'(n_resp), 64'd1);
        chk("cmd0_resp_lat", 64'(t_resp - t_r1), 64'd1);
        chk("cmd0_nerr", 64'(n_err), 64'd0);

        // CMD8 with tx_ready toggling: CRC 0x43 -> tail 0x87
        clr(); crc_val = 7'h43; rdy_toggle = 1;
        rx_script.push_back(8'h01);
        start_cmd(6'd8, 32'h0000_01AA);
        wait_done("cmd8", 300);
        rdy_toggle = 0; i_tx_ready = 1'b1;
        chk_frame("cmd8", 48'h48_00_00_01_AA_87);
        chk("cmd8_stab_seen", 64'(n_stab > 0), 64'd1);
        chk("cmd8_resp", 64'(o_resp), 64'h01);
        chk("cmd8_nresp", 64'(n_resp), 64'd1);

        // CRC timeout: no crc_done. 64 CRC_WAIT cycles, then the registered
        // err pulse appears one cycle later -> 65 cycles after crc_init.
        clr(); crc_en = 0;
        start_cmd(6'd17, 32'h1234_5678);
        wait_done("crcto", 200);
        chk("crcto_nerr", 64'(n_err), 64'd1);
        chk("crcto_lat", 64'(t_err - t_crc_init), 64'd65);
        chk("crcto_no_txv", 64'(t_first_txv), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("crcto_busy", 64'(o_busy), 64'd0);
        chk("crcto_nresp", 64'(n_resp), 64'd0);
        crc_en = 1;

        // NCR timeout: every poll answered 0xFF -> 6 frame + 8 poll bytes
        clr(); crc_val = 7'h00;
        start_cmd(6'd1, 32'h0);
        wait_done("ncrto", 300);
        chk_frame("ncrto", 48'h41_00_00_00_00_01);
        chk("ncrto_nbytes", 64'(sent_q.size()), 64'd14);
        chk("ncrto_nerr", 64'(n_err), 64'd1);
        chk("ncrto_nresp", 64'(n_resp), 64'd0);

        // Reset after byte2 accepted
        clr(); crc_val = 7'h4A;
        start_cmd(6'd0, 32'h0);
        wait_sent("rst_mid", 3, 100);
        reset = 1'b1;
        tick();
        chk_idle_zero("rst_mid_outs");
        reset = 1'b0;
        clr();
        for (int i = 0; i < 4; i++) tick();
        chk("rst_mid_quiet", 64'(n_resp + n_err + n_crc_init + sent_q.size()), 64'd0);
        rx_script.push_back(8'h01);
        start_cmd(6'd0, 32'h0);
        wait_done("rst_new", 200);
        chk_frame("rst_new", 48'h40_00_00_00_00_95);
        chk("rst_new_resp", 64'(o_resp), 64'h01);

        // cmd_start during POLL is ignored
        clr(); crc_val = 7'h4A;
        rx_script.push_back(8'hFF); rx_script.push_back(8'hFF);
        rx_script.push_back(8'hFF); rx_script.push_back(8'h00);
        start_cmd(6'd55, 32'hCAFE_0001);
        wait_sent("ign", 7, 100);
        i_cmd_start = 1'b1; i_cmd_index = 6'd1; i_cmd_arg = 32'hFFFF_FFFF;
        tick();
        i_cmd_start = 1'b0;
        wait_done("ign", 200);
        chk_frame("ign", 48'h77_CA_FE_00_01_95);
        chk("ign_din", 64'(din_at_init), 64'h77_CAFE_0001);
        chk("ign_ninit", 64'(n_crc_init), 64'd1);
        chk("ign_nbytes", 64'(sent_q.size()), 64'd10);
        chk("ign_resp", 64'(o_resp), 64'h00);
        chk("ign_nresp", 64'(n_resp), 64'd1);
        tick(); tick();
        chk("ign_idle", 64'(o_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
